// File: rtl/vga_pkg.sv
// Shared VGA definitions for the cursor controller slice.
// Holds the default active-area geometry, the coordinate width used by the
// vga block, the cursor FSM state encoding, and the per-axis direction decode.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int COORD_W      = 11;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] MOVING = 1'b1;

    // Opposing buttons pressed together cancel out.
    function automatic logic signed [1:0] axis_dir(input logic pos, input logic neg);
        if (pos && !neg) begin
            return 2'sd1;
        end else if (neg && !pos) begin
            return -2'sd1;
        end else begin
            return 2'sd0;
        end
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw asynchronous button.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both stages
//   d     - raw asynchronous input
//   q     - synchronized output, two clk cycles behind d
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cursor_ctrl.sv
// Frame-synchronous cursor position controller.
// Moves a CURSOR_W x CURSOR_H box from four direction buttons once per frame
// (at vertical-blank entry), accelerating while a direction is held and
// clamping at the screen edges. Also produces the registered pixel hit flag.
// Ports:
//   CLOCK_50     - system clock
//   reset        - asynchronous active-low reset
//   x_coord      - current pixel column from the vga block
//   y_coord      - current pixel line from the vga block
//   btn_*        - raw asynchronous active-high direction buttons
//   cursor_x/y   - left/top edge of the cursor box
//   is_on_cursor - current pixel lies inside the cursor (one cycle late)
module cursor_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int CURSOR_W     = 8,
    parameter int CURSOR_H     = 8,
    parameter int STEP_MIN     = 1,
    parameter int STEP_MAX     = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [COORD_W-1:0] x_coord,
    input  logic [COORD_W-1:0] y_coord,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic               is_on_cursor
);

    localparam int SPD_W  = $clog2(STEP_MAX + 1);
    localparam int HOLD_W = $clog2(ACCEL_FRAMES + 1);
    localparam int X_MAX  = H_ACTIVE - CURSOR_W;
    localparam int Y_MAX  = V_ACTIVE - CURSOR_H;

    localparam logic [COORD_W-1:0] X_CENTRE = COORD_W'(X_MAX / 2);
    localparam logic [COORD_W-1:0] Y_CENTRE = COORD_W'(Y_MAX / 2);

    // Signed displacement of one axis: dir * step.
    function automatic logic signed [COORD_W:0] axis_offset(
        input logic signed [1:0] dir,
        input logic [SPD_W-1:0]  step
    );
        logic signed [COORD_W:0] step_s;
        step_s = signed'((COORD_W + 1)'(step));
        case (dir)
            2'sd1:   return step_s;
            -2'sd1:  return -step_s;
            default: return '0;
        endcase
    endfunction

    // Saturate a signed candidate position into [0, hi]; never wraps.
    function automatic logic [COORD_W-1:0] clamp_pos(
        input logic signed [COORD_W:0] v,
        input int                      hi
    );
        if (v < 0) begin
            return '0;
        end else if (int'(v) > hi) begin
            return COORD_W'(hi);
        end else begin
            return v[COORD_W-1:0];
        end
    endfunction

    logic up_s, down_s, left_s, right_s;

    btn_sync u_sync_up    (.clk(CLOCK_50), .rst_n(reset), .d(btn_up),    .q(up_s));
    btn_sync u_sync_down  (.clk(CLOCK_50), .rst_n(reset), .d(btn_down),  .q(down_s));
    btn_sync u_sync_left  (.clk(CLOCK_50), .rst_n(reset), .d(btn_left),  .q(left_s));
    btn_sync u_sync_right (.clk(CLOCK_50), .rst_n(reset), .d(btn_right), .q(right_s));

    logic [COORD_W-1:0] cursor_x_d, cursor_x_q;
    logic [COORD_W-1:0] cursor_y_d, cursor_y_q;
    logic [SPD_W-1:0]   speed_d, speed_q;
    logic [HOLD_W-1:0]  hold_cnt_d, hold_cnt_q;
    logic [0:0]         state_d, state_q;
    logic               vblank_d, vblank_q;
    logic               hit_d, hit_q;

    logic signed [1:0]  dx, dy;
    logic               any_act;
    logic               tick;
    logic               do_move;
    logic [SPD_W-1:0]   move_spd;
    logic [COORD_W:0]   x_ext, y_ext, cx_ext, cy_ext;

    always_comb begin
        dx      = axis_dir(right_s, left_s);
        dy      = axis_dir(down_s, up_s);
        any_act = (dx != 2'sd0) || (dy != 2'sd0);

        // vblank_q resets to 1 so a reset released inside blanking does not
        // produce a tick until the next genuine blank entry.
        vblank_d = (int'(y_coord) >= V_ACTIVE);
        tick     = vblank_d && !vblank_q;

        state_d    = state_q;
        speed_d    = speed_q;
        hold_cnt_d = hold_cnt_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        do_move    = 1'b0;
        move_spd   = speed_q;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (any_act) begin
                        do_move    = 1'b1;
                        move_spd   = SPD_W'(STEP_MIN);
                        speed_d    = SPD_W'(STEP_MIN);
                        hold_cnt_d = HOLD_W'(1);
                        state_d    = MOVING;
                    end
                end
                default: begin
                    if (any_act) begin
                        do_move = 1'b1;
                        if (int'(hold_cnt_q) + 1 >= ACCEL_FRAMES) begin
                            hold_cnt_d = '0;
                            speed_d    = (int'(speed_q) >= STEP_MAX) ? SPD_W'(STEP_MAX)
                                                                     : speed_q + SPD_W'(1);
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end else begin
                        state_d    = IDLE;
                        speed_d    = SPD_W'(STEP_MIN);
                        hold_cnt_d = '0;
                    end
                end
            endcase
        end

        if (do_move) begin
            cursor_x_d = clamp_pos(signed'({1'b0, cursor_x_q}) + axis_offset(dx, move_spd), X_MAX);
            cursor_y_d = clamp_pos(signed'({1'b0, cursor_y_q}) + axis_offset(dy, move_spd), Y_MAX);
        end

        // Extended by one bit so cursor + size cannot overflow the compare.
        x_ext  = {1'b0, x_coord};
        y_ext  = {1'b0, y_coord};
        cx_ext = {1'b0, cursor_x_q};
        cy_ext = {1'b0, cursor_y_q};
        hit_d  = (x_ext >= cx_ext) && (x_ext < cx_ext + (COORD_W + 1)'(CURSOR_W)) &&
                 (y_ext >= cy_ext) && (y_ext < cy_ext + (COORD_W + 1)'(CURSOR_H));
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            cursor_x_q <= X_CENTRE;
            cursor_y_q <= Y_CENTRE;
            speed_q    <= SPD_W'(STEP_MIN);
            hold_cnt_q <= '0;
            state_q    <= IDLE;
            vblank_q   <= 1'b1;
            hit_q      <= 1'b0;
        end else begin
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            speed_q    <= speed_d;
            hold_cnt_q <= hold_cnt_d;
            state_q    <= state_d;
            vblank_q   <= vblank_d;
            hit_q      <= hit_d;
        end
    end

    assign cursor_x     = cursor_x_q;
    assign cursor_y     = cursor_y_q;
    assign is_on_cursor = hit_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed testbench for cursor_ctrl with default parameters.
// Frames are compressed: a few active lines (y=0) followed by blanking (y=500).
module tb_cursor_ctrl;

    logic        clk;
    logic        reset;
    logic [10:0] x_coord;
    logic [10:0] y_coord;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic [10:0] cursor_x, cursor_y;
    logic        is_on_cursor;

    int checks = 0;
    int errors = 0;

    cursor_ctrl dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .is_on_cursor(is_on_cursor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One compressed frame; exactly one blank entry, so exactly one tick.
    task automatic frame();
        y_coord = 11'd0;
        x_coord = 11'd0;
        cyc(4);
        y_coord = 11'd500;
        cyc(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        x_coord = 11'd0;
        y_coord = 11'd0;
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        logic [10:0] hx [8];
        logic [10:0] hy [8];
        logic        he [8];
        hx = '{11'd316, 11'd323, 11'd315, 11'd324, 11'd316, 11'd316, 11'd320, 11'd320};
        hy = '{11'd236, 11'd243, 11'd236, 11'd236, 11'd244, 11'd235, 11'd240, 11'd500};
        he = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0};

        @(negedge clk);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        x_coord = 11'd316;
        y_coord = 11'd236;
        reset = 1'b0;
        #1;
        checks++;
        if (cursor_x !== 11'd316 || cursor_y !== 11'd236 || is_on_cursor !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got x=%0d y=%0d hit=%0b, want x=316 y=236 hit=0",
                     cursor_x, cursor_y, is_on_cursor);
        end
        cyc(2);
        reset = 1'b1;
        for (int f = 0; f < 3; f++) frame();
        checks++;
        if (cursor_x !== 11'd316 || cursor_y !== 11'd236) begin
            errors++;
            $display("FAIL idle_hold: got x=%0d y=%0d, want x=316 y=236", cursor_x, cursor_y);
        end

        // Hit flag: coordinate applied at a negedge, registered at the next posedge.
        for (int i = 0; i < 8; i++) begin
            x_coord = hx[i];
            y_coord = hy[i];
            @(negedge clk);
            checks++;
            if (is_on_cursor !== he[i]) begin
                errors++;
                $display("FAIL hit_%0d: at (%0d,%0d) got %0b, want %0b",
                         i, hx[i], hy[i], is_on_cursor, he[i]);
            end
        end
        // Latency: move inside, sample before the next active edge -> still old value.
        x_coord = 11'd318;
        y_coord = 11'd238;
        #1;
        checks++;
        if (is_on_cursor !== 1'b0) begin
            errors++;
            $display("FAIL hit_latency: got %0b before clock edge, want 0", is_on_cursor);
        end
        @(negedge clk);
        checks++;
        if (is_on_cursor !== 1'b1) begin
            errors++;
            $display("FAIL hit_after_edge: got %0b, want 1", is_on_cursor);
        end
    endtask

    task automatic test_right_accel();
        logic [10:0] ex [10];
        ex = '{11'd317, 11'd318, 11'd319, 11'd320, 11'd322,
               11'd324, 11'd326, 11'd328, 11'd331, 11'd334};
        do_reset();
        btn_right = 1'b1;
        for (int f = 0; f < 10; f++) begin
            frame();
            checks++;
            if (cursor_x !== ex[f]) begin
                errors++;
                $display("FAIL right_accel_f%0d: got x=%0d, want %0d", f + 1, cursor_x, ex[f]);
            end
        end
        btn_right = 1'b0;
        frame();
    endtask

    task automatic test_left_saturate();
        do_reset();
        btn_left = 1'b1;
        // 4*1 + 4*2 + ... + 4*8 = 144 over 32 frames, then 8/frame (capped).
        for (int f = 0; f < 36; f++) frame();
        checks++;
        if (cursor_x !== 11'd140) begin
            errors++;
            $display("FAIL left_speed_cap: got x=%0d, want 140", cursor_x);
        end
        for (int f = 0; f < 164; f++) frame();
        checks++;
        if (cursor_x !== 11'd0 || cursor_y !== 11'd236) begin
            errors++;
            $display("FAIL left_saturate: got x=%0d y=%0d, want x=0 y=236", cursor_x, cursor_y);
        end
        btn_left = 1'b0;
        frame();
    endtask

    task automatic test_opposing();
        do_reset();
        btn_up = 1'b1; btn_down = 1'b1; btn_right = 1'b1;
        for (int f = 0; f < 5; f++) frame();
        checks++;
        if (cursor_x !== 11'd322 || cursor_y !== 11'd236) begin
            errors++;
            $display("FAIL opposing_moving: got x=%0d y=%0d, want x=322 y=236", cursor_x, cursor_y);
        end
        btn_right = 1'b0;
        frame();
        checks++;
        if (cursor_x !== 11'd322 || cursor_y !== 11'd236) begin
            errors++;
            $display("FAIL opposing_only: got x=%0d y=%0d, want x=322 y=236", cursor_x, cursor_y);
        end
        btn_up = 1'b0;
        frame();
        checks++;
        if (cursor_y !== 11'd237 || cursor_x !== 11'd322) begin
            errors++;
            $display("FAIL down_after_idle: got x=%0d y=%0d, want x=322 y=237", cursor_x, cursor_y);
        end
        btn_down = 1'b0;
        frame();
    endtask

    task automatic test_no_tick_pulse();
        do_reset();
        x_coord = 11'd50;
        y_coord = 11'd100;
        btn_right = 1'b1;
        cyc(100);
        btn_right = 1'b0;
        cyc(5);
        frame();
        checks++;
        if (cursor_x !== 11'd316) begin
            errors++;
            $display("FAIL pulse_no_move: got x=%0d, want 316", cursor_x);
        end
        btn_right = 1'b1;
        frame();
        checks++;
        if (cursor_x !== 11'd317) begin
            errors++;
            $display("FAIL pulse_then_idle_move: got x=%0d, want 317", cursor_x);
        end
        btn_right = 1'b0;
        frame();
    endtask

    task automatic test_reset_midframe();
        do_reset();
        btn_right = 1'b1;
        for (int f = 0; f < 16; f++) frame();
        checks++;
        if (cursor_x !== 11'd356) begin
            errors++;
            $display("FAIL pre_reset_16: got x=%0d, want 356", cursor_x);
        end
        frame();
        checks++;
        if (cursor_x !== 11'd361) begin
            errors++;
            $display("FAIL speed5_move: got x=%0d, want 361", cursor_x);
        end
        y_coord = 11'd100;
        cyc(2);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (cursor_x !== 11'd316 || cursor_y !== 11'd236) begin
            errors++;
            $display("FAIL async_reset: got x=%0d y=%0d, want x=316 y=236", cursor_x, cursor_y);
        end
        @(negedge clk);
        y_coord = 11'd500;
        cyc(2);
        reset = 1'b1;
        cyc(4);
        checks++;
        if (cursor_x !== 11'd316) begin
            errors++;
            $display("FAIL no_tick_after_release: got x=%0d, want 316", cursor_x);
        end
        frame();
        checks++;
        if (cursor_x !== 11'd317) begin
            errors++;
            $display("FAIL speed_reset: got x=%0d, want 317", cursor_x);
        end
        btn_right = 1'b0;
        frame();
        // Hit test follows the moved cursor.
        x_coord = 11'd324;
        y_coord = 11'd243;
        @(negedge clk);
        checks++;
        if (is_on_cursor !== 1'b1) begin
            errors++;
            $display("FAIL hit_moved_in: got %0b, want 1", is_on_cursor);
        end
        x_coord = 11'd316;
        @(negedge clk);
        checks++;
        if (is_on_cursor !== 1'b0) begin
            errors++;
            $display("FAIL hit_moved_out: got %0b, want 0", is_on_cursor);
        end
    endtask

    initial begin
        reset = 1'b1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        x_coord = 11'd0;
        y_coord = 11'd0;
        test_reset();
        test_right_accel();
        test_left_saturate();
        test_opposing();
        test_no_tick_pulse();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
